// File: rtl/ripple_count_monitor.sv
// ripple_count_monitor
//
// Consumer-side sequence checker for a counter's q bus. Every enabled sample
// is classified against the previous sample. The three classes are INC
// (+1 mod 2^WIDTH), HOLD (unchanged) and BAD (anything else). A small FSM
// tracks lock. When it loses lock it reports step and stall errors. It also
// counts wrap-arounds (all-ones -> 0) seen while locked. All outputs are
// registered. The response to a sample appears right after its sampling edge.
//
// Parameters
//   WIDTH     width of the monitored count bus
//   LOCK_N    consecutive valid increments needed to declare lock (>= 1)
//   MAX_HOLD  consecutive held samples that count as a stall (0 = stall check off)
//   WRAPW     width of the saturating wrap counter
//
// Ports
//   clk         in   rising-edge clock
//   reset       in   asynchronous, active-high reset
//   q_in        in   count bus, settled at the sampling edge
//   en          in   sample strobe; q_in is evaluated only when en=1
//   clear_err   in   synchronous clear of err_sticky (honoured regardless of en)
//   locked      out  high while the FSM is LOCKED
//   step_err    out  1-cycle pulse: illegal step while LOCKED
//   stall_err   out  1-cycle pulse: hold limit reached while LOCKED
//   err_sticky  out  set by step_err/stall_err, cleared by clear_err
//   wrap_pulse  out  1-cycle pulse on an all-ones -> 0 step while LOCKED
//   wrap_cnt    out  saturating count of wrap_pulse events
//   last_q      out  last sampled q_in

module ripple_count_monitor #(
    parameter int WIDTH    = 4,
    parameter int LOCK_N   = 3,
    parameter int MAX_HOLD = 7,
    parameter int WRAPW    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] q_in,
    input  logic             en,
    input  logic             clear_err,
    output logic             locked,
    output logic             step_err,
    output logic             stall_err,
    output logic             err_sticky,
    output logic             wrap_pulse,
    output logic [WRAPW-1:0] wrap_cnt,
    output logic [WIDTH-1:0] last_q
);

    // Counter widths: each is just wide enough to hold its terminal value.
    localparam int RW = (LOCK_N < 2) ? 1 : $clog2(LOCK_N + 1);
    localparam int HW = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);

    localparam logic [WIDTH-1:0] Q_ONE    = WIDTH'(1);
    localparam logic [RW-1:0]    RUN_ONE  = RW'(1);
    localparam logic [RW-1:0]    RUN_MAX  = RW'(LOCK_N);
    localparam logic [HW:0]      HOLD_ONE = (HW + 1)'(1);
    localparam logic [HW:0]      HOLD_MAX = (HW + 1)'(MAX_HOLD);
    localparam logic [WRAPW-1:0] WRAP_ONE = WRAPW'(1);

    typedef enum logic [1:0] {
        S_UNLOCKED,
        S_LOCKING,
        S_LOCKED,
        S_FAULT
    } state_t;

    state_t           state_q, state_d;
    logic [RW-1:0]    run_q, run_d;
    logic [HW-1:0]    hold_cnt_q, hold_cnt_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic             locked_q, locked_d;
    logic             step_err_q, step_err_d;
    logic             stall_err_q, stall_err_d;
    logic             err_sticky_q, err_sticky_d;
    logic             wrap_pulse_q, wrap_pulse_d;
    logic [WRAPW-1:0] wrap_cnt_q, wrap_cnt_d;

    // Sample classification against the previous sample.
    logic [WIDTH-1:0] prev_plus1;
    logic             is_inc;
    logic             is_hold;
    logic             is_wrap;
    logic [RW-1:0]    run_inc;
    logic             run_hit;
    logic [HW:0]      hold_inc;
    logic             hold_hit;
    logic [HW-1:0]    hold_sat;

    // The hold counter is one bit wider so the compare against MAX_HOLD cannot
    // alias. With the stall check disabled it simply saturates.
    assign prev_plus1 = prev_q + Q_ONE;
    assign is_inc     = (q_in == prev_plus1);
    assign is_hold    = (q_in == prev_q);
    assign is_wrap    = (prev_q == '1) && (q_in == '0);
    assign run_inc    = run_q + RUN_ONE;
    assign run_hit    = (run_inc == RUN_MAX);
    assign hold_inc   = {1'b0, hold_cnt_q} + HOLD_ONE;
    assign hold_hit   = (MAX_HOLD != 0) && (hold_inc == HOLD_MAX);
    assign hold_sat   = hold_inc[HW] ? hold_cnt_q : hold_inc[HW-1:0];

    // State register: every flop of the block lives here.
    // NOTE: sequential state uses non-blocking assignments so that all flops
    // update together from values sampled before the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_UNLOCKED;
            run_q        <= '0;
            hold_cnt_q   <= '0;
            prev_q       <= '0;
            locked_q     <= 1'b0;
            step_err_q   <= 1'b0;
            stall_err_q  <= 1'b0;
            err_sticky_q <= 1'b0;
            wrap_pulse_q <= 1'b0;
            wrap_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            run_q        <= run_d;
            hold_cnt_q   <= hold_cnt_d;
            prev_q       <= prev_d;
            locked_q     <= locked_d;
            step_err_q   <= step_err_d;
            stall_err_q  <= stall_err_d;
            err_sticky_q <= err_sticky_d;
            wrap_pulse_q <= wrap_pulse_d;
            wrap_cnt_q   <= wrap_cnt_d;
        end
    end

    // Next-state logic: FSM state plus the run/hold trackers and prev.
    always_comb begin
        // NOTE: every signal gets a hold-value default first, so no path can
        // leave it unassigned and infer a latch.
        state_d    = state_q;
        run_d      = run_q;
        hold_cnt_d = hold_cnt_q;
        prev_d     = prev_q;

        if (en) begin
            prev_d = q_in;
            case (state_q)
                // A FAULT is treated exactly like a fresh start.
                S_UNLOCKED, S_FAULT: begin
                    state_d    = S_LOCKING;
                    run_d      = '0;
                    hold_cnt_d = '0;
                end
                S_LOCKING: begin
                    if (is_inc) begin
                        hold_cnt_d = '0;
                        if (run_hit) begin
                            state_d = S_LOCKED;
                            run_d   = '0;
                        end else begin
                            run_d = run_inc;
                        end
                    end else if (is_hold) begin
                        // A long hold during acquisition restarts the run quietly.
                        if (hold_hit) begin
                            run_d      = '0;
                            hold_cnt_d = '0;
                        end else begin
                            hold_cnt_d = hold_sat;
                        end
                    end else begin
                        run_d      = '0;
                        hold_cnt_d = '0;
                    end
                end
                S_LOCKED: begin
                    if (is_inc) begin
                        hold_cnt_d = '0;
                    end else if (is_hold) begin
                        if (hold_hit) begin
                            state_d    = S_FAULT;
                            hold_cnt_d = '0;
                        end else begin
                            hold_cnt_d = hold_sat;
                        end
                    end else begin
                        state_d = S_FAULT;
                    end
                end
                default: begin
                    state_d = S_UNLOCKED;
                end
            endcase
        end
    end

    // Output logic: computes the next value of every registered output.
    always_comb begin
        step_err_d   = en && (state_q == S_LOCKED) && !is_inc && !is_hold;
        stall_err_d  = en && (state_q == S_LOCKED) && is_hold && hold_hit;
        wrap_pulse_d = en && (state_q == S_LOCKED) && is_wrap;
        locked_d     = (state_d == S_LOCKED);

        wrap_cnt_d = wrap_cnt_q;
        if (wrap_pulse_d && (wrap_cnt_q != '1)) begin
            wrap_cnt_d = wrap_cnt_q + WRAP_ONE;
        end

        // A new error wins over a clear on the same edge.
        err_sticky_d = err_sticky_q;
        if (step_err_d || stall_err_d) begin
            err_sticky_d = 1'b1;
        end else if (clear_err) begin
            err_sticky_d = 1'b0;
        end
    end

    assign locked     = locked_q;
    assign step_err   = step_err_q;
    assign stall_err  = stall_err_q;
    assign err_sticky = err_sticky_q;
    assign wrap_pulse = wrap_pulse_q;
    assign wrap_cnt   = wrap_cnt_q;
    assign last_q     = prev_q;

endmodule

// File: tb/tb_ripple_count_monitor.sv
// tb_ripple_count_monitor
//
// Directed bench for ripple_count_monitor. Two instances share the stimulus:
// dut_a uses the default parameters, and dut_b has the stall check off
// (MAX_HOLD=0) with a 2-bit wrap counter (WRAPW=2). Each output vector packs
// {locked, step_err, stall_err, err_sticky, wrap_pulse, wrap_cnt, last_q}.

module tb_ripple_count_monitor;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       clear_err;
    logic [3:0] q_in;

    logic       a_locked, a_step_err, a_stall_err, a_err_sticky, a_wrap_pulse;
    logic [7:0] a_wrap_cnt;
    logic [3:0] a_last_q;
    logic       b_locked, b_step_err, b_stall_err, b_err_sticky, b_wrap_pulse;
    logic [1:0] b_wrap_cnt;
    logic [3:0] b_last_q;

    int checks = 0;
    int errors = 0;

    logic [16:0] a_vec;
    logic [10:0] b_vec;
    assign a_vec = {a_locked, a_step_err, a_stall_err, a_err_sticky, a_wrap_pulse, a_wrap_cnt, a_last_q};
    assign b_vec = {b_locked, b_step_err, b_stall_err, b_err_sticky, b_wrap_pulse, b_wrap_cnt, b_last_q};

    ripple_count_monitor #(.WIDTH(4), .LOCK_N(3), .MAX_HOLD(7), .WRAPW(8)) dut_a (
        .clk(clk), .reset(reset), .q_in(q_in), .en(en), .clear_err(clear_err),
        .locked(a_locked), .step_err(a_step_err), .stall_err(a_stall_err),
        .err_sticky(a_err_sticky), .wrap_pulse(a_wrap_pulse),
        .wrap_cnt(a_wrap_cnt), .last_q(a_last_q)
    );

    ripple_count_monitor #(.WIDTH(4), .LOCK_N(3), .MAX_HOLD(0), .WRAPW(2)) dut_b (
        .clk(clk), .reset(reset), .q_in(q_in), .en(en), .clear_err(clear_err),
        .locked(b_locked), .step_err(b_step_err), .stall_err(b_stall_err),
        .err_sticky(b_err_sticky), .wrap_pulse(b_wrap_pulse),
        .wrap_cnt(b_wrap_cnt), .last_q(b_last_q)
    );

    always #5 clk = ~clk;

    // Apply one sample, clock it in, and settle 1 time unit past the edge.
    task automatic step(input logic [3:0] q, input logic e);
        q_in = q;
        en   = e;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        en        = 1'b0;
        clear_err = 1'b0;
        reset     = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; en = 1'b0; clear_err = 1'b0; q_in = 4'd0;
        #1 reset = 1'b1;
        #2;
        checks++;
        if (a_vec !== 17'd0) begin errors++; $display("FAIL reset_async_a: got %h expected %h", a_vec, 17'd0); end
        checks++;
        if (b_vec !== 11'd0) begin errors++; $display("FAIL reset_async_b: got %h expected %h", b_vec, 11'd0); end
        @(posedge clk);
        #1 reset = 1'b0;
        step(4'd6, 1'b0);
        checks++;
        if (a_vec !== 17'd0) begin errors++; $display("FAIL reset_idle: got %h expected %h", a_vec, 17'd0); end
    endtask

    // Count 0..15,0,1: lock after the q=3 sample, one wrap on the q=0 sample.
    task automatic test_count();
        logic [16:0] exp;
        for (int i = 0; i < 18; i++) begin
            step(4'(i % 16), 1'b1);
            exp = {(i >= 3) ? 1'b1 : 1'b0, 3'b000, (i == 16) ? 1'b1 : 1'b0,
                   (i >= 16) ? 8'd1 : 8'd0, 4'(i % 16)};
            checks++;
            if (a_vec !== exp) begin errors++; $display("FAIL count[%0d]: got %h expected %h", i, a_vec, exp); end
        end
    endtask

    // Continues from test_count (locked, last_q=1, wrap_cnt=1).
    task automatic test_step_err();
        logic [16:0] exp;
        for (int v = 2; v <= 5; v++) step(4'(v), 1'b1);
        checks++;
        exp = {1'b1, 3'b000, 1'b0, 8'd1, 4'd5};
        if (a_vec !== exp) begin errors++; $display("FAIL step_pre: got %h expected %h", a_vec, exp); end
        step(4'd7, 1'b1);
        checks++;
        exp = {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd1, 4'd7};
        if (a_vec !== exp) begin errors++; $display("FAIL step_err_pulse: got %h expected %h", a_vec, exp); end
        step(4'd3, 1'b0);
        checks++;
        exp = {1'b0, 3'b001, 1'b0, 8'd1, 4'd7};
        if (a_vec !== exp) begin errors++; $display("FAIL step_err_drop: got %h expected %h", a_vec, exp); end
        for (int v = 8; v <= 11; v++) begin
            step(4'(v), 1'b1);
            exp = {(v == 11) ? 1'b1 : 1'b0, 3'b001, 1'b0, 8'd1, 4'(v)};
            checks++;
            if (a_vec !== exp) begin errors++; $display("FAIL relock[%0d]: got %h expected %h", v, a_vec, exp); end
        end
    endtask

    // Lock at 4 and hold. dut_a stalls on the 7th hold; dut_b never stalls.
    task automatic test_stall();
        logic [16:0] exp_a;
        logic [10:0] exp_b;
        do_reset();
        for (int v = 1; v <= 4; v++) step(4'(v), 1'b1);
        checks++;
        exp_a = {1'b1, 3'b000, 1'b0, 8'd0, 4'd4};
        if (a_vec !== exp_a) begin errors++; $display("FAIL stall_pre: got %h expected %h", a_vec, exp_a); end
        for (int h = 1; h <= 20; h++) begin
            step(4'd4, 1'b1);
            if (h <= 8) begin
                if (h < 7)       exp_a = {1'b1, 3'b000, 1'b0, 8'd0, 4'd4};
                else if (h == 7) exp_a = {1'b0, 3'b011, 1'b0, 8'd0, 4'd4};
                else             exp_a = {1'b0, 3'b001, 1'b0, 8'd0, 4'd4};
                checks++;
                if (a_vec !== exp_a) begin errors++; $display("FAIL stall_a[%0d]: got %h expected %h", h, a_vec, exp_a); end
            end
            exp_b = {1'b1, 3'b000, 1'b0, 2'd0, 4'd4};
            checks++;
            if (b_vec !== exp_b) begin errors++; $display("FAIL nostall_b[%0d]: got %h expected %h", h, b_vec, exp_b); end
        end
    endtask

    task automatic test_en_low();
        logic [16:0] exp;
        do_reset();
        for (int v = 0; v <= 5; v++) step(4'(v), 1'b1);
        for (int k = 0; k < 10; k++) begin
            step(4'($urandom_range(0, 15)), 1'b0);
            exp = {1'b1, 3'b000, 1'b0, 8'd0, 4'd5};
            checks++;
            if (a_vec !== exp) begin errors++; $display("FAIL en_low[%0d]: got %h expected %h", k, a_vec, exp); end
        end
        for (int v = 6; v <= 7; v++) begin
            step(4'(v), 1'b1);
            exp = {1'b1, 3'b000, 1'b0, 8'd0, 4'(v)};
            checks++;
            if (a_vec !== exp) begin errors++; $display("FAIL en_resume[%0d]: got %h expected %h", v, a_vec, exp); end
        end
    endtask

    task automatic test_clear_same_edge();
        logic [16:0] exp;
        do_reset();
        for (int v = 0; v <= 3; v++) step(4'(v), 1'b1);
        clear_err = 1'b1;
        step(4'd9, 1'b1);
        checks++;
        exp = {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 4'd9};
        if (a_vec !== exp) begin errors++; $display("FAIL clear_vs_err: got %h expected %h", a_vec, exp); end
        step(4'd2, 1'b0);
        checks++;
        exp = {1'b0, 3'b000, 1'b0, 8'd0, 4'd9};
        if (a_vec !== exp) begin errors++; $display("FAIL clear_alone: got %h expected %h", a_vec, exp); end
        clear_err = 1'b0;
    endtask

    // Five full wraps: dut_b saturates at 3, dut_a reaches 5. Then a mid-cycle reset.
    task automatic test_wrap_sat();
        logic [10:0] exp_b;
        logic [16:0] exp_a;
        int wraps;
        int sat;
        logic wp;
        do_reset();
        wraps = 0;
        for (int i = 0; i <= 80; i++) begin
            step(4'(i % 16), 1'b1);
            wp = (i >= 16) && (i % 16 == 0);
            if (wp) wraps++;
            sat = (wraps > 3) ? 3 : wraps;
            exp_b = {(i >= 3) ? 1'b1 : 1'b0, 3'b000, wp, 2'(sat), 4'(i % 16)};
            checks++;
            if (b_vec !== exp_b) begin errors++; $display("FAIL wrap_b[%0d]: got %h expected %h", i, b_vec, exp_b); end
        end
        checks++;
        if (a_wrap_cnt !== 8'd5) begin errors++; $display("FAIL wrap_a_cnt: got %0d expected 5", a_wrap_cnt); end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (a_vec !== 17'd0) begin errors++; $display("FAIL midreset_a: got %h expected %h", a_vec, 17'd0); end
        checks++;
        if (b_vec !== 11'd0) begin errors++; $display("FAIL midreset_b: got %h expected %h", b_vec, 11'd0); end
        @(posedge clk);
        #1 reset = 1'b0;
        for (int v = 9; v <= 12; v++) begin
            step(4'(v), 1'b1);
            exp_a = {(v == 12) ? 1'b1 : 1'b0, 3'b000, 1'b0, 8'd0, 4'(v)};
            checks++;
            if (a_vec !== exp_a) begin errors++; $display("FAIL post_reset[%0d]: got %h expected %h", v, a_vec, exp_a); end
        end
    endtask

    initial begin
        test_reset();
        test_count();
        test_step_err();
        test_stall();
        test_en_low();
        test_clear_same_edge();
        test_wrap_sat();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
